// File: rtl/mac3_pkg.sv
// Shared types for the mac3 streaming multiply-add family.
// Mode and run-tracking state encodings used by the top level and its testbench.
package mac3_pkg;

  typedef enum logic {
    MODE_BLOCK = 1'b0,
    MODE_SLIDE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_TWO  = 2'd2,
    ST_FULL = 2'd3
  } state_e;

endpackage

// File: rtl/mac3_datapath.sv
// Combinational a*b+c at full precision, folded to a WIDTH-bit result plus overflow flag.
// Kept free of state so multi-lane variants can replicate it directly.
module mac3_datapath #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam int FW = 2 * WIDTH + 1;

  logic [FW-1:0] full;

  // Widen every operand first so neither the product nor the carry of the add is lost.
  always_comb begin
    full = FW'(a) * FW'(b) + FW'(c);
    res  = full[WIDTH-1:0];
    ovf  = |full[FW-1:WIDTH];
  end

endmodule

// File: rtl/mac3_stream.sv
// Streaming a*b+c over runs of valid words, in disjoint-triplet or sliding-window mode.
// Holds the run FSM, word history, per-run mode capture, result registers and result counter.
module mac3_stream
  import mac3_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validi,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic             valido,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf,
  output logic [CNT_W-1:0] res_cnt
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [WIDTH-1:0]  w1_q, w1_d;
  logic [WIDTH-1:0]  w2_q, w2_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              emit;
  logic [WIDTH-1:0]  macRes;
  logic              macOvf;

  // The third operand is always the word arriving now, so the two most recent
  // accepted words are the only history the arithmetic ever needs.
  mac3_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .a  (w1_q),
    .b  (w2_q),
    .c  (data_in),
    .res(macRes),
    .ovf(macOvf)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    emit    = 1'b0;

    if (!validi) begin
      state_d = ST_IDLE;
    end else begin
      w1_d = w2_q;
      w2_d = data_in;
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ONE;
          mode_d  = mode_e'(mode);
        end
        ST_ONE: state_d = ST_TWO;
        ST_TWO: begin
          emit    = 1'b1;
          state_d = (mode_q == MODE_SLIDE) ? ST_FULL : ST_IDLE;
        end
        ST_FULL: begin
          emit    = 1'b1;
          state_d = (mode_q == MODE_SLIDE) ? ST_FULL : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    valid_d = emit;
    data_d  = emit ? macRes : data_q;
    ovf_d   = emit ? macOvf : ovf_q;
    cnt_d   = emit ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BLOCK;
      w1_q    <= '0;
      w2_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valido   = valid_q;
  assign data_out = data_q;
  assign ovf      = ovf_q;
  assign res_cnt  = cnt_q;

endmodule

// File: tb/tb_mac3_stream.sv
// Directed bench for mac3_stream at WIDTH=8, CNT_W=2 with hand-computed results.
// A small counter model tracks the expected res_cnt, including its wrap.
module tb_mac3_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             validi;
  logic [WIDTH-1:0] data_in;
  logic             mode;
  logic             valido;
  logic [WIDTH-1:0] data_out;
  logic             ovf;
  logic [CNT_W-1:0] res_cnt;

  int               errors;
  int               checks;
  logic [CNT_W-1:0] expCnt;

  mac3_stream #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .validi  (validi),
    .data_in (data_in),
    .mode    (mode),
    .valido  (valido),
    .data_out(data_out),
    .ovf     (ovf),
    .res_cnt (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input away from the edge, then settle just after the edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic m);
    @(negedge clk);
    validi  = v;
    data_in = d;
    mode    = m;
    @(posedge clk);
    #1;
  endtask

  task automatic stepWord(input string tag, input logic v, input logic [WIDTH-1:0] d,
                          input logic m, input logic expValid);
    applyStimulus(v, d, m);
    checkOutput({tag, ".valido"}, 32'(valido), 32'(expValid));
    checkOutput({tag, ".res_cnt"}, 32'(res_cnt), 32'(expCnt));
  endtask

  task automatic expectResult(input string tag, input logic v, input logic [WIDTH-1:0] d,
                              input logic m, input logic [WIDTH-1:0] expData,
                              input logic expOvf);
    expCnt = expCnt + 1'b1;
    stepWord(tag, v, d, m, 1'b1);
    checkOutput({tag, ".data_out"}, 32'(data_out), 32'(expData));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, ".valido"}, 32'(valido), 32'd0);
    checkOutput({tag, ".data_out"}, 32'(data_out), 32'd0);
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'd0);
    checkOutput({tag, ".res_cnt"}, 32'(res_cnt), 32'd0);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    expCnt  = '0;
    rst     = 1'b1;
    validi  = 1'b0;
    data_in = '0;
    mode    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // BLOCK triplets, back to back
    stepWord("blk345.w0", 1, 8'd3, 0, 0);
    stepWord("blk345.w1", 1, 8'd4, 0, 0);
    expectResult("blk345", 1, 8'd5, 0, 8'd17, 0);
    stepWord("blk222.w0", 1, 8'd2, 0, 0);
    stepWord("blk222.w1", 1, 8'd2, 0, 0);
    expectResult("blk222", 1, 8'd2, 0, 8'd6, 0);
    stepWord("hold", 0, 8'd0, 0, 0);
    checkOutput("hold.data_out", 32'(data_out), 32'd6);

    // Overflow cases
    stepWord("ovf1.w0", 1, 8'd20, 0, 0);
    stepWord("ovf1.w1", 1, 8'd20, 0, 0);
    expectResult("ovf400", 1, 8'd0, 0, 8'd144, 1);
    stepWord("ovf2.w0", 1, 8'd255, 0, 0);
    stepWord("ovf2.w1", 1, 8'd255, 0, 0);
    expectResult("ovfmax", 1, 8'd255, 0, 8'd0, 1);
    stepWord("gap1", 0, 8'd0, 0, 0);
    checkOutput("gap1.ovf", 32'(ovf), 32'd1);

    // SLIDE continuous window
    stepWord("sld.w1", 1, 8'd1, 1, 0);
    stepWord("sld.w2", 1, 8'd2, 1, 0);
    expectResult("sld.r5", 1, 8'd3, 1, 8'd5, 0);
    expectResult("sld.r10", 1, 8'd4, 1, 8'd10, 0);
    expectResult("sld.r17", 1, 8'd5, 1, 8'd17, 0);
    stepWord("sld.gap", 0, 8'd0, 1, 0);

    // BLOCK gap aborts the partial triplet
    stepWord("bgap.w7", 1, 8'd7, 0, 0);
    stepWord("bgap.w8", 1, 8'd8, 0, 0);
    stepWord("bgap.gap", 0, 8'd0, 0, 0);
    stepWord("bgap.w1", 1, 8'd1, 0, 0);
    stepWord("bgap.w2", 1, 8'd2, 0, 0);
    expectResult("bgap.r5", 1, 8'd3, 0, 8'd5, 0);
    stepWord("bgap.idle", 0, 8'd0, 0, 0);

    // SLIDE gap aborts the window
    stepWord("sgap.w1", 1, 8'd1, 1, 0);
    stepWord("sgap.w2", 1, 8'd2, 1, 0);
    expectResult("sgap.r5", 1, 8'd3, 1, 8'd5, 0);
    stepWord("sgap.gap", 0, 8'd0, 1, 0);
    stepWord("sgap.w4", 1, 8'd4, 1, 0);
    checkOutput("sgap.w4.data_out", 32'(data_out), 32'd5);
    stepWord("sgap.idle", 0, 8'd0, 1, 0);

    // Mode flip mid-run is ignored until the run ends
    stepWord("mchg.w1", 1, 8'd1, 1, 0);
    stepWord("mchg.w2", 1, 8'd2, 1, 0);
    expectResult("mchg.r5", 1, 8'd3, 1, 8'd5, 0);
    expectResult("mchg.r10", 1, 8'd4, 0, 8'd10, 0);
    expectResult("mchg.r17", 1, 8'd5, 0, 8'd17, 0);
    stepWord("mchg.gap", 0, 8'd0, 0, 0);
    stepWord("mchg.w6", 1, 8'd6, 0, 0);
    stepWord("mchg.w7", 1, 8'd7, 0, 0);
    expectResult("mchg.r50", 1, 8'd8, 0, 8'd50, 0);
    stepWord("mchg.w9", 1, 8'd9, 0, 0);
    stepWord("mchg.idle", 0, 8'd0, 0, 0);

    // Asynchronous reset between the 2nd and 3rd word
    stepWord("rst.w1", 1, 8'd1, 0, 0);
    stepWord("rst.w2", 1, 8'd2, 0, 0);
    @(negedge clk);
    validi = 1'b0;
    #1;
    checkOutput("rst.pre.res_cnt", 32'(res_cnt), 32'(expCnt));
    rst = 1'b1;
    #1;
    checkCleared("rst.async");
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    expCnt = '0;

    // Five triplets after reset walk res_cnt through its wrap
    stepWord("wrap1.w0", 1, 8'd3, 0, 0);
    stepWord("wrap1.w1", 1, 8'd4, 0, 0);
    expectResult("wrap1", 1, 8'd5, 0, 8'd17, 0);
    stepWord("wrap2.w0", 1, 8'd1, 0, 0);
    stepWord("wrap2.w1", 1, 8'd1, 0, 0);
    expectResult("wrap2", 1, 8'd1, 0, 8'd2, 0);
    stepWord("wrap3.w0", 1, 8'd2, 0, 0);
    stepWord("wrap3.w1", 1, 8'd3, 0, 0);
    expectResult("wrap3", 1, 8'd4, 0, 8'd10, 0);
    stepWord("wrap4.w0", 1, 8'd10, 0, 0);
    stepWord("wrap4.w1", 1, 8'd10, 0, 0);
    expectResult("wrap4", 1, 8'd10, 0, 8'd110, 0);
    checkOutput("wrap4.zero", 32'(res_cnt), 32'd0);
    stepWord("wrap5.w0", 1, 8'd16, 0, 0);
    stepWord("wrap5.w1", 1, 8'd16, 0, 0);
    expectResult("wrap5", 1, 8'd0, 0, 8'd0, 1);
    checkOutput("wrap5.one", 32'(res_cnt), 32'd1);
    stepWord("end", 0, 8'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac3_stream.md
# mac3_stream

Parametrised streaming multiply-add unit. It takes a word stream qualified by `validi` and, over runs of consecutive valid words, computes `a*b+c` from three successive words. It supports two runtime modes: non-overlapping triplets and a sliding window. It adds configurable width, overflow detection and a wrapping result counter. It sits on the `data_in`/`validi` streaming path and drives a registered result port to downstream logic.

## Interface
- `WIDTH`, 32, data word and result width (≥2)
- `CNT_W`, 16, width of the result counter
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `validi`  in  1  `data_in` valid this cycle; low breaks the current run
- `data_in`  in  WIDTH  input word, unsigned
- `mode`  in  1  0 = BLOCK (disjoint triplets), 1 = SLIDE (overlapping window)
- `valido`  out  1  one-cycle pulse: `data_out`/`ovf` carry a new result
- `data_out`  out  WIDTH  low WIDTH bits of `a*b+c`; holds last result otherwise
- `ovf`  out  1  true result ≥ 2^WIDTH; valid with `valido`, held with `data_out`
- `res_cnt`  out  CNT_W  number of results emitted since reset, wraps modulo 2^CNT_W

## Operation
- A word is accepted on each rising edge with `validi=1`. A 3-deep history (w0 oldest, w1, w2) shifts on every accepted word.
- Any cycle with `validi=0` returns the FSM to IDLE. History contents are don't-care after that point. `data_out`, `ovf` and `res_cnt` are not changed.
- FSM states: IDLE (0 words in run), ONE, TWO, FULL.
- BLOCK mode transitions:
  - IDLE→ONE→TWO on accepted words.
  - TWO + accepted word → IDLE and emit, with a=w(first), b=w(second), c=data_in.
  - FULL is unreachable.
- SLIDE mode transitions:
  - IDLE→ONE→TWO on accepted words.
  - TWO + accepted word → FULL and emit.
  - FULL + accepted word → FULL and emit, using the last three accepted words including the current one: a oldest, c newest.
- Mode is captured into `mode_q` only on a transition out of IDLE, i.e. on the first word of a run. Changes to `mode` mid-run are ignored until the run ends.
- Arithmetic:
  - Full-precision unsigned sum `a*b + c` at 2*WIDTH+1 bits.
  - `data_out` = low WIDTH bits.
  - `ovf` = OR of the upper WIDTH+1 bits.
- Emit means register `data_out` and `ovf`, set `valido=1` for exactly the next cycle, and increment `res_cnt`. `res_cnt` wraps from all-ones to 0 with no flag.
- Reset values: `valido=0`, `data_out=0`, `ovf=0`, `res_cnt=0`, state IDLE, history 0, `mode_q=0`.
- Reset mid-run: the partial run is discarded; the first post-reset accepted word starts a new run in ONE.

## Timing
- Latency is 1. The result for a third/window word accepted at edge k is visible immediately after edge k, with `valido` high until edge k+1.
- BLOCK throughput: one result per 3 accepted words.
- SLIDE throughput: one result per accepted word once in FULL. `valido` is therefore high back-to-back for continuous input.
- A gap of one cycle in TWO or FULL aborts the pending window. No result is emitted for the aborted window.
- Simultaneous gap and mode change: the run ends, and the new mode applies from the next accepted word.
- The multiply-add path is single-cycle combinational into the output register. No backpressure; the consumer must sample on `valido`.

## Structure
- Package `mac3_pkg`:
  - `mode_e` {MODE_BLOCK, MODE_SLIDE}
  - `state_e` {ST_IDLE, ST_ONE, ST_TWO, ST_FULL}
- Sub-module `mac3_datapath`, parameter `WIDTH`. It is purely combinational: inputs a, b, c; outputs `res[WIDTH-1:0]` and `ovf`. It is reused by later multi-lane variants.
- The top level holds the FSM, history shift register, mode capture, output registers and counter.

## Test plan
- WIDTH=8, BLOCK, words 3,4,5 on three consecutive cycles → one `valido` pulse after the third edge, `data_out=17`, `ovf=0`, `res_cnt=1`. Words 2,2,2 next → `data_out=6`, `res_cnt=2`.
- WIDTH=8, BLOCK, words 20,20,0 → `data_out=144`, `ovf=1`. Words 255,255,255 → `data_out=0`, `ovf=1`.
- WIDTH=8, SLIDE, words 1,2,3,4,5 continuous → `valido` high 3 consecutive cycles, `data_out` 5, 10, 17.
- Gap handling: BLOCK words 7,8, `validi=0`, then 1,2,3 → a single result of 5, and `res_cnt` increments by 1 only. SLIDE run 1,2,3, gap, then 4 → no result after the 4.
- Mode change mid-run: start SLIDE with 1,2,3, switch `mode=0` while feeding 4,5 continuously → results 5, 10, 17 (still SLIDE). After a gap, 6,7,8 → a single result of 50.
- Assert `rst` between the 2nd and 3rd word of a triplet → all outputs 0 asynchronously. A following 3,4,5 → 17, `res_cnt=1`. With CNT_W=2, 5 triplets → `res_cnt` reads 1,2,3,0,1.
